mem_port_arbiter: RTL

//  Shares the single data-memory port between instruction fetch (FE) and the MEM stage.

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between instruction fetch (FE) and the
//   MEM stage. One access is sequenced at a time over a valid/ready port; the
//   winner gets its read data plus a one-cycle done pulse. MEM has priority,
//   but an FE request left pending for FE_MAX_WAIT cycles overrides it. An
//   access that sees no port_rdy_i for TIMEOUT cycles is aborted and flagged
//   on the sticky err_o.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   fe_req_i, fe_addr_i          fetch read request / address (held until done)
//   fe_done_o, fe_data_o         one-cycle completion pulse, instruction word
//   fe_stall_o                   fe_req_i && !fe_done_o
//   mem_req_i, mem_r_w_i,        MEM-stage request, 1=write, size (B/H/W/D),
//   mem_size_i, mem_addr_i,      address, store data
//   mem_wdata_i
//   mem_done_o, mem_rdata_o      one-cycle completion pulse, load data
//   mem_stall_o                  mem_req_i && !mem_done_o
//   port_v_o, port_r_w_o,        access towards the memory file, held constant
//   port_size_o, port_addr_o,    for the whole access
//   port_wdata_o
//   port_rdata_i, port_rdy_i     read data and completion from the memory file
//   err_o                        sticky access-timeout flag

module mem_port_arbiter #(
  parameter int FE_MAX_WAIT = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fe_req_i,
  input  logic [63:0] fe_addr_i,
  output logic        fe_done_o,
  output logic [31:0] fe_data_o,
  output logic        fe_stall_o,
  input  logic        mem_req_i,
  input  logic        mem_r_w_i,
  input  logic [1:0]  mem_size_i,
  input  logic [63:0] mem_addr_i,
  input  logic [63:0] mem_wdata_i,
  output logic        mem_done_o,
  output logic [63:0] mem_rdata_o,
  output logic        mem_stall_o,
  output logic        port_v_o,
  output logic        port_r_w_o,
  output logic [1:0]  port_size_o,
  output logic [63:0] port_addr_o,
  output logic [63:0] port_wdata_o,
  input  logic [63:0] port_rdata_i,
  input  logic        port_rdy_i,
  output logic        err_o
);

  localparam int WW = $clog2(FE_MAX_WAIT) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(FE_MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FE_ACC  = 2'd1,
    S_MEM_ACC = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          port_v_q, port_v_d;
  logic          port_r_w_q, port_r_w_d;
  logic [1:0]    port_size_q, port_size_d;
  logic [63:0]   port_addr_q, port_addr_d;
  logic [63:0]   port_wdata_q, port_wdata_d;
  logic          fe_done_q, fe_done_d;
  logic [31:0]   fe_data_q, fe_data_d;
  logic          mem_done_q, mem_done_d;
  logic [63:0]   mem_rdata_q, mem_rdata_d;
  logic          err_q, err_d;
  logic [WW-1:0] fe_wait_q, fe_wait_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          grant_fe;

  // FE wins only when MEM is absent or FE has waited long enough.
  assign grant_fe = fe_req_i && (!mem_req_i || (fe_wait_q >= WAIT_MAX));

  always_comb begin
    state_d      = state_q;
    port_v_d     = port_v_q;
    port_r_w_d   = port_r_w_q;
    port_size_d  = port_size_q;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    fe_done_d    = 1'b0;
    fe_data_d    = fe_data_q;
    mem_done_d   = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    err_d        = err_q;
    tmo_d        = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (grant_fe) begin
          state_d      = S_FE_ACC;
          port_v_d     = 1'b1;
          port_r_w_d   = 1'b0;
          port_size_d  = 2'b10;
          port_addr_d  = fe_addr_i;
          port_wdata_d = 64'd0;
          tmo_d        = '0;
        end else if (mem_req_i) begin
          state_d      = S_MEM_ACC;
          port_v_d     = 1'b1;
          port_r_w_d   = mem_r_w_i;
          port_size_d  = mem_size_i;
          port_addr_d  = mem_addr_i;
          port_wdata_d = mem_wdata_i;
          tmo_d        = '0;
        end
      end

      S_FE_ACC, S_MEM_ACC: begin
        // A ready arriving on the final allowed cycle still completes normally.
        if (port_v_q && port_rdy_i) begin
          state_d  = S_IDLE;
          port_v_d = 1'b0;
          if (state_q == S_FE_ACC) begin
            fe_done_d = 1'b1;
            fe_data_d = port_rdata_i[31:0];
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = port_rdata_i;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_IDLE;
          port_v_d = 1'b0;
          err_d    = 1'b1;
          if (state_q == S_FE_ACC) begin
            fe_done_d = 1'b1;
            fe_data_d = 32'd0;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = 64'd0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        port_v_d = 1'b0;
      end
    endcase
  end

  // Starvation counter: counts FE-pending cycles outside FE_ACC, saturating.
  always_comb begin
    fe_wait_d = fe_wait_q;
    if (!fe_req_i) begin
      fe_wait_d = '0;
    end else if ((state_q == S_IDLE) && grant_fe) begin
      fe_wait_d = '0;
    end else if ((state_q != S_FE_ACC) && (fe_wait_q < WAIT_MAX)) begin
      fe_wait_d = fe_wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      port_v_q     <= 1'b0;
      port_r_w_q   <= 1'b0;
      port_size_q  <= 2'b00;
      port_addr_q  <= 64'd0;
      port_wdata_q <= 64'd0;
      fe_done_q    <= 1'b0;
      fe_data_q    <= 32'd0;
      mem_done_q   <= 1'b0;
      mem_rdata_q  <= 64'd0;
      err_q        <= 1'b0;
      fe_wait_q    <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      port_v_q     <= port_v_d;
      port_r_w_q   <= port_r_w_d;
      port_size_q  <= port_size_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      fe_done_q    <= fe_done_d;
      fe_data_q    <= fe_data_d;
      mem_done_q   <= mem_done_d;
      mem_rdata_q  <= mem_rdata_d;
      err_q        <= err_d;
      fe_wait_q    <= fe_wait_d;
      tmo_q        <= tmo_d;
    end
  end

  assign fe_done_o    = fe_done_q;
  assign fe_data_o    = fe_data_q;
  assign fe_stall_o   = fe_req_i && !fe_done_q;
  assign mem_done_o   = mem_done_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign mem_stall_o  = mem_req_i && !mem_done_q;
  assign port_v_o     = port_v_q;
  assign port_r_w_o   = port_r_w_q;
  assign port_size_o  = port_size_q;
  assign port_addr_o  = port_addr_q;
  assign port_wdata_o = port_wdata_q;
  assign err_o        = err_q;

endmodule
